// File: rtl/oh_regpipe.sv
// Elastic valid/ready register pipeline: DEPTH stages, each a stall register
// or (REGREADY=1) a two-entry skid buffer that cuts the ready path at every stage.
module oh_regpipe #(
    parameter int DW       = 32,
    parameter int DEPTH    = 2,
    parameter bit REGREADY = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;
            assign busy      = 1'b0;
        end else begin : g_pipe
            logic          flush;
            logic [DEPTH-1:0] main_v;
            logic [DEPTH-1:0] skid_v;
            logic [DW-1:0] main_d [DEPTH];
            logic [DW-1:0] skid_d [DEPTH];
            logic [DEPTH:0]   rdy;
            logic [DEPTH-1:0] up_v;
            logic [DW-1:0] up_d [DEPTH];
            logic [DEPTH-1:0] take;
            logic [DEPTH-1:0] drain;

            assign flush = reset | clear;

            // rdy[k] is the ready seen by the producer feeding stage k; rdy[DEPTH] is the sink.
            always_comb begin
                rdy  = '0;
                up_v = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    up_d[k] = '0;
                end
                rdy[DEPTH] = out_ready;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (REGREADY) begin
                        rdy[k] = !skid_v[k];
                    end else begin
                        rdy[k] = !main_v[k] | rdy[k+1];
                    end
                end
                up_v[0] = in_valid & !flush;
                up_d[0] = in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    up_v[k] = main_v[k-1];
                    up_d[k] = main_d[k-1];
                end
                take  = up_v & rdy[DEPTH-1:0];
                drain = ~main_v | rdy[DEPTH:1];
            end

            // Main register always presents the oldest entry; skid only catches a word
            // that arrived while main was stuck, and refills main as soon as it drains.
            always_ff @(posedge clk) begin
                if (reset) begin
                    main_v <= '0;
                    skid_v <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        main_d[k] <= '0;
                        skid_d[k] <= '0;
                    end
                end else if (clear) begin
                    main_v <= '0;
                    skid_v <= '0;
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (drain[k]) begin
                            if (skid_v[k]) begin
                                main_v[k] <= 1'b1;
                                main_d[k] <= skid_d[k];
                                skid_v[k] <= 1'b0;
                            end else begin
                                main_v[k] <= take[k];
                                if (take[k]) begin
                                    main_d[k] <= up_d[k];
                                end
                            end
                        end else if (REGREADY && take[k]) begin
                            skid_v[k] <= 1'b1;
                            skid_d[k] <= up_d[k];
                        end
                    end
                end
            end

            assign in_ready  = rdy[0] & !flush;
            assign out_valid = main_v[DEPTH-1] & !reset;
            assign out_data  = reset ? '0 : main_d[DEPTH-1];
            assign busy      = (|main_v) | (|skid_v);
        end
    endgenerate

endmodule
